axi_lite_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite arbiter that lets `mriscvcore` (master 0) share its single memory/peripheral bus with a second master (master 1: program loader or debug port). One transaction is in flight at a time. Grant alternates round-robin between masters and is held until the transaction's response handshake completes. The block sits between the core's AXI4-Lite pins and the bus slave, and is transparent to the core apart from added grant latency.

---
 rtl/axi_lite_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_axi_lite_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_arbiter.sv
// Two-master, one-slave AXI4-Lite arbiter: one transaction in flight, round-robin grant
// held from address phase through response handshake.
module axi_lite_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_ARvalid,
    input  logic [31:0] m0_ARdata,
    input  logic [2:0]  m0_ARprot,
    input  logic        m0_RReady,
    output logic        m0_ARready,
    output logic        m0_Rvalid,
    output logic [31:0] m0_Rdata,
    input  logic        m0_AWvalid,
    input  logic [31:0] m0_AWdata,
    input  logic [2:0]  m0_AWprot,
    input  logic        m0_Wvalid,
    input  logic [31:0] m0_Wdata,
    input  logic [3:0]  m0_Wstrb,
    input  logic        m0_Bready,
    output logic        m0_AWready,
    output logic        m0_Wready,
    output logic        m0_Bvalid,

    input  logic        m1_ARvalid,
    input  logic [31:0] m1_ARdata,
    input  logic [2:0]  m1_ARprot,
    input  logic        m1_RReady,
    output logic        m1_ARready,
    output logic        m1_Rvalid,
    output logic [31:0] m1_Rdata,
    input  logic        m1_AWvalid,
    input  logic [31:0] m1_AWdata,
    input  logic [2:0]  m1_AWprot,
    input  logic        m1_Wvalid,
    input  logic [31:0] m1_Wdata,
    input  logic [3:0]  m1_Wstrb,
    input  logic        m1_Bready,
    output logic        m1_AWready,
    output logic        m1_Wready,
    output logic        m1_Bvalid,

    output logic        s_ARvalid,
    output logic [31:0] s_ARdata,
    output logic [2:0]  s_ARprot,
    output logic        s_RReady,
    output logic        s_AWvalid,
    output logic [31:0] s_AWdata,
    output logic [2:0]  s_AWprot,
    output logic        s_Wvalid,
    output logic [31:0] s_Wdata,
    output logic [3:0]  s_Wstrb,
    output logic        s_Bready,
    input  logic        s_ARready,
    input  logic        s_Rvalid,
    input  logic [31:0] s_Rdata,
    input  logic        s_AWready,
    input  logic        s_Wready,
    input  logic        s_Bvalid,

    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP} state_t;

    state_t state, state_nx;
    logic   owner, owner_nx;
    logic   last, last_nx;
    logic   aw_done, aw_done_nx;
    logic   w_done, w_done_nx;
    logic   req0, req1, sel;
    logic   aw_hs, w_hs;

    // Owner-side view of the master inputs
    logic        o_ARvalid, o_RReady, o_AWvalid, o_Wvalid, o_Bready;
    logic [31:0] o_ARdata, o_AWdata, o_Wdata;
    logic [2:0]  o_ARprot, o_AWprot;
    logic [3:0]  o_Wstrb;

    // Owner-side outputs before demultiplexing to the masters
    logic        o_ARready, o_Rvalid, o_AWready, o_Wready, o_Bvalid;
    logic [31:0] o_Rdata;

    assign req0 = m0_ARvalid | m0_AWvalid;
    assign req1 = m1_ARvalid | m1_AWvalid;
    assign sel  = (req0 & req1) ? ~last : req1;

    always_comb begin
        o_ARvalid = owner ? m1_ARvalid : m0_ARvalid;
        o_ARdata  = owner ? m1_ARdata  : m0_ARdata;
        o_ARprot  = owner ? m1_ARprot  : m0_ARprot;
        o_RReady  = owner ? m1_RReady  : m0_RReady;
        o_AWvalid = owner ? m1_AWvalid : m0_AWvalid;
        o_AWdata  = owner ? m1_AWdata  : m0_AWdata;
        o_AWprot  = owner ? m1_AWprot  : m0_AWprot;
        o_Wvalid  = owner ? m1_Wvalid  : m0_Wvalid;
        o_Wdata   = owner ? m1_Wdata   : m0_Wdata;
        o_Wstrb   = owner ? m1_Wstrb   : m0_Wstrb;
        o_Bready  = owner ? m1_Bready  : m0_Bready;
    end

    assign aw_hs = o_AWvalid & ~aw_done & s_AWready;
    assign w_hs  = o_Wvalid  & ~w_done  & s_Wready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            last    <= last_nx;
            aw_done <= aw_done_nx;
            w_done  <= w_done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        last_nx    = last;
        aw_done_nx = aw_done;
        w_done_nx  = w_done;
        unique case (state)
            IDLE: begin
                aw_done_nx = 1'b0;
                w_done_nx  = 1'b0;
                if (req0 | req1) begin
                    owner_nx = sel;
                    last_nx  = sel;
                    state_nx = (sel ? m1_ARvalid : m0_ARvalid) ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: if (o_ARvalid & s_ARready) state_nx = RD_RESP;
            RD_RESP: if (s_Rvalid & o_RReady)   state_nx = IDLE;
            WR_REQ: begin
                aw_done_nx = aw_done | aw_hs;
                w_done_nx  = w_done | w_hs;
                if (aw_done_nx & w_done_nx) state_nx = WR_RESP;
            end
            WR_RESP: if (s_Bvalid & o_Bready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_ARvalid = 1'b0;
        s_ARdata  = '0;
        s_ARprot  = '0;
        s_RReady  = 1'b0;
        s_AWvalid = 1'b0;
        s_AWdata  = '0;
        s_AWprot  = '0;
        s_Wvalid  = 1'b0;
        s_Wdata   = '0;
        s_Wstrb   = '0;
        s_Bready  = 1'b0;
        o_ARready = 1'b0;
        o_Rvalid  = 1'b0;
        o_Rdata   = '0;
        o_AWready = 1'b0;
        o_Wready  = 1'b0;
        o_Bvalid  = 1'b0;
        unique case (state)
            RD_ADDR: begin
                s_ARvalid = o_ARvalid;
                s_ARdata  = o_ARdata;
                s_ARprot  = o_ARprot;
                o_ARready = s_ARready;
            end
            RD_RESP: begin
                s_RReady = o_RReady;
                o_Rvalid = s_Rvalid;
                o_Rdata  = s_Rdata;
            end
            WR_REQ: begin
                // Each channel is masked once its handshake has happened
                s_AWvalid = o_AWvalid & ~aw_done;
                s_AWdata  = o_AWdata;
                s_AWprot  = o_AWprot;
                o_AWready = s_AWready & ~aw_done;
                s_Wvalid  = o_Wvalid & ~w_done;
                s_Wdata   = o_Wdata;
                s_Wstrb   = o_Wstrb;
                o_Wready  = s_Wready & ~w_done;
            end
            WR_RESP: begin
                s_Bready = o_Bready;
                o_Bvalid = s_Bvalid;
            end
            default: ;
        endcase
    end

    assign m0_ARready = o_ARready & ~owner;
    assign m0_Rvalid  = o_Rvalid  & ~owner;
    assign m0_Rdata   = owner ? '0 : o_Rdata;
    assign m0_AWready = o_AWready & ~owner;
    assign m0_Wready  = o_Wready  & ~owner;
    assign m0_Bvalid  = o_Bvalid  & ~owner;

    assign m1_ARready = o_ARready & owner;
    assign m1_Rvalid  = o_Rvalid  & owner;
    assign m1_Rdata   = owner ? o_Rdata : '0;
    assign m1_AWready = o_AWready & owner;
    assign m1_Wready  = o_Wready  & owner;
    assign m1_Bvalid  = o_Bvalid  & owner;

    assign busy  = (state != IDLE);
    assign grant = busy ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: reads, writes with slave stalls, round-robin,
// read-before-write ordering, response back-pressure and reset mid-transaction.
module tb_axi_lite_arbiter;

    logic        clock, reset;
    logic        m0_ARvalid, m0_RReady, m0_AWvalid, m0_Wvalid, m0_Bready;
    logic [31:0] m0_ARdata, m0_AWdata, m0_Wdata;
    logic [2:0]  m0_ARprot, m0_AWprot;
    logic [3:0]  m0_Wstrb;
    logic        m0_ARready, m0_Rvalid, m0_AWready, m0_Wready, m0_Bvalid;
    logic [31:0] m0_Rdata;
    logic        m1_ARvalid, m1_RReady, m1_AWvalid, m1_Wvalid, m1_Bready;
    logic [31:0] m1_ARdata, m1_AWdata, m1_Wdata;
    logic [2:0]  m1_ARprot, m1_AWprot;
    logic [3:0]  m1_Wstrb;
    logic        m1_ARready, m1_Rvalid, m1_AWready, m1_Wready, m1_Bvalid;
    logic [31:0] m1_Rdata;
    logic        s_ARvalid, s_RReady, s_AWvalid, s_Wvalid, s_Bready;
    logic [31:0] s_ARdata, s_AWdata, s_Wdata;
    logic [2:0]  s_ARprot, s_AWprot;
    logic [3:0]  s_Wstrb;
    logic        s_ARready, s_Rvalid, s_AWready, s_Wready, s_Bvalid;
    logic [31:0] s_Rdata;
    logic [1:0]  grant;
    logic        busy;

    logic [36:0]  m1_out;
    logic [187:0] all_out;
    int n_cmp = 0;
    int n_fail = 0;

    assign m1_out  = {m1_ARready, m1_Rvalid, m1_Rdata, m1_AWready, m1_Wready, m1_Bvalid};
    assign all_out = {m0_ARready, m0_Rvalid, m0_Rdata, m0_AWready, m0_Wready, m0_Bvalid,
                      m1_out,
                      s_ARvalid, s_ARdata, s_ARprot, s_RReady, s_AWvalid, s_AWdata, s_AWprot,
                      s_Wvalid, s_Wdata, s_Wstrb, s_Bready, grant, busy};

    axi_lite_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_ARvalid(m0_ARvalid), .m0_ARdata(m0_ARdata), .m0_ARprot(m0_ARprot), .m0_RReady(m0_RReady),
        .m0_ARready(m0_ARready), .m0_Rvalid(m0_Rvalid), .m0_Rdata(m0_Rdata),
        .m0_AWvalid(m0_AWvalid), .m0_AWdata(m0_AWdata), .m0_AWprot(m0_AWprot),
        .m0_Wvalid(m0_Wvalid), .m0_Wdata(m0_Wdata), .m0_Wstrb(m0_Wstrb), .m0_Bready(m0_Bready),
        .m0_AWready(m0_AWready), .m0_Wready(m0_Wready), .m0_Bvalid(m0_Bvalid),
        .m1_ARvalid(m1_ARvalid), .m1_ARdata(m1_ARdata), .m1_ARprot(m1_ARprot), .m1_RReady(m1_RReady),
        .m1_ARready(m1_ARready), .m1_Rvalid(m1_Rvalid), .m1_Rdata(m1_Rdata),
        .m1_AWvalid(m1_AWvalid), .m1_AWdata(m1_AWdata), .m1_AWprot(m1_AWprot),
        .m1_Wvalid(m1_Wvalid), .m1_Wdata(m1_Wdata), .m1_Wstrb(m1_Wstrb), .m1_Bready(m1_Bready),
        .m1_AWready(m1_AWready), .m1_Wready(m1_Wready), .m1_Bvalid(m1_Bvalid),
        .s_ARvalid(s_ARvalid), .s_ARdata(s_ARdata), .s_ARprot(s_ARprot), .s_RReady(s_RReady),
        .s_AWvalid(s_AWvalid), .s_AWdata(s_AWdata), .s_AWprot(s_AWprot),
        .s_Wvalid(s_Wvalid), .s_Wdata(s_Wdata), .s_Wstrb(s_Wstrb), .s_Bready(s_Bready),
        .s_ARready(s_ARready), .s_Rvalid(s_Rvalid), .s_Rdata(s_Rdata),
        .s_AWready(s_AWready), .s_Wready(s_Wready), .s_Bvalid(s_Bvalid),
        .grant(grant), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        m0_ARvalid = 0; m0_ARdata = '0; m0_ARprot = '0; m0_RReady = 0;
        m0_AWvalid = 0; m0_AWdata = '0; m0_AWprot = '0;
        m0_Wvalid = 0; m0_Wdata = '0; m0_Wstrb = '0; m0_Bready = 0;
        m1_ARvalid = 0; m1_ARdata = '0; m1_ARprot = '0; m1_RReady = 0;
        m1_AWvalid = 0; m1_AWdata = '0; m1_AWprot = '0;
        m1_Wvalid = 0; m1_Wdata = '0; m1_Wstrb = '0; m1_Bready = 0;
        s_ARready = 0; s_Rvalid = 0; s_Rdata = '0;
        s_AWready = 0; s_Wready = 0; s_Bvalid = 0;
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [31:0] exp_addr;

        clear_inputs();
        reset = 1;
        cyc(); cyc(); #1;
        chk("reset_all_out", all_out, '0);

        // m0 minimum read
        cyc(); reset = 0; m0_ARvalid = 1; m0_ARdata = 32'h0000_1000; m0_ARprot = 3'b010; #1;
        chk("rd_c0_grant", grant, 2'b00);
        chk("rd_c0_s_ARvalid", s_ARvalid, 1'b0);
        cyc(); s_ARready = 1; #1;
        chk("rd_c1_grant", grant, 2'b01);
        chk("rd_c1_busy", busy, 1'b1);
        chk("rd_c1_s_ARvalid", s_ARvalid, 1'b1);
        chk("rd_c1_s_ARdata", s_ARdata, 32'h0000_1000);
        chk("rd_c1_s_ARprot", s_ARprot, 3'b010);
        chk("rd_c1_m0_ARready", m0_ARready, 1'b1);
        chk("rd_c1_m1_out", m1_out, '0);
        cyc(); m0_ARvalid = 0; s_ARready = 0; s_Rvalid = 1; s_Rdata = 32'hDEAD_BEEF; m0_RReady = 1; #1;
        chk("rd_c2_grant", grant, 2'b01);
        chk("rd_c2_m0_Rvalid", m0_Rvalid, 1'b1);
        chk("rd_c2_m0_Rdata", m0_Rdata, 32'hDEAD_BEEF);
        chk("rd_c2_s_RReady", s_RReady, 1'b1);
        chk("rd_c2_m1_out", m1_out, '0);
        chk("rd_c2_s_ARvalid", s_ARvalid, 1'b0);
        cyc(); clear_inputs(); #1;
        chk("rd_c3_busy", busy, 1'b0);
        chk("rd_c3_all_out", all_out, '0);

        // m1 write, AW accepted at cycle 1, W stalled until cycle 4
        cyc(); m1_AWvalid = 1; m1_AWdata = 32'h0000_2000; m1_Wvalid = 1; m1_Wdata = 32'hCAFE_0000;
        m1_Wstrb = 4'hC; m1_Bready = 1; #1;
        chk("wr_c0_busy", busy, 1'b0);
        cyc(); s_AWready = 1; #1;
        chk("wr_c1_grant", grant, 2'b10);
        chk("wr_c1_s_AWvalid", s_AWvalid, 1'b1);
        chk("wr_c1_s_AWdata", s_AWdata, 32'h0000_2000);
        chk("wr_c1_s_Wvalid", s_Wvalid, 1'b1);
        chk("wr_c1_s_Wdata", s_Wdata, 32'hCAFE_0000);
        chk("wr_c1_s_Wstrb", s_Wstrb, 4'hC);
        chk("wr_c1_m1_AWready", m1_AWready, 1'b1);
        chk("wr_c1_m1_Wready", m1_Wready, 1'b0);
        chk("wr_c1_s_Bready", s_Bready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(); s_AWready = 0; s_Wready = 0; #1;
            chk("wr_stall_s_AWvalid", s_AWvalid, 1'b0);
            chk("wr_stall_s_Wvalid", s_Wvalid, 1'b1);
            chk("wr_stall_s_Bready", s_Bready, 1'b0);
            chk("wr_stall_grant", grant, 2'b10);
        end
        cyc(); s_Wready = 1; #1;
        chk("wr_c4_s_Wvalid", s_Wvalid, 1'b1);
        chk("wr_c4_m1_Wready", m1_Wready, 1'b1);
        chk("wr_c4_s_AWvalid", s_AWvalid, 1'b0);
        chk("wr_c4_s_Bready", s_Bready, 1'b0);
        cyc(); m1_AWvalid = 0; m1_Wvalid = 0; s_Wready = 0; #1;
        chk("wr_c5_busy", busy, 1'b1);
        chk("wr_c5_s_Bready", s_Bready, 1'b1);
        chk("wr_c5_m1_Bvalid", m1_Bvalid, 1'b0);
        chk("wr_c5_s_Wvalid", s_Wvalid, 1'b0);
        cyc(); s_Bvalid = 1; #1;
        chk("wr_c6_m1_Bvalid", m1_Bvalid, 1'b1);
        chk("wr_c6_m0_Bvalid", m0_Bvalid, 1'b0);
        chk("wr_c6_grant", grant, 2'b10);
        cyc(); clear_inputs(); #1;
        chk("wr_c7_busy", busy, 1'b0);
        chk("wr_c7_grant", grant, 2'b00);

        // Both masters read continuously: m0, m1, m0, m1
        cyc(); m0_ARvalid = 1; m0_ARdata = 32'h0000_00A0; m1_ARvalid = 1; m1_ARdata = 32'h0000_00B0;
        m0_RReady = 1; m1_RReady = 1; s_ARready = 1; s_Rvalid = 1; s_Rdata = 32'h1234_5678; #1;
        chk("rr_c0_busy", busy, 1'b0);
        for (int t = 0; t < 4; t++) begin
            exp_g    = (t % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (t % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B0;
            cyc(); #1;
            chk("rr_addr_grant", grant, exp_g);
            chk("rr_addr_s_ARdata", s_ARdata, exp_addr);
            cyc(); #1;
            chk("rr_resp_grant", grant, exp_g);
            chk("rr_resp_Rvalid", {m1_Rvalid, m0_Rvalid}, exp_g);
            chk("rr_resp_s_ARvalid", s_ARvalid, 1'b0);
            cyc(); if (t == 3) clear_inputs(); #1;
            chk("rr_idle_grant", grant, 2'b00);
            chk("rr_idle_busy", busy, 1'b0);
        end

        // m0 read and write together: read first, write on next IDLE
        cyc(); m0_ARvalid = 1; m0_ARdata = 32'h0000_3000; m0_AWvalid = 1; m0_AWdata = 32'h0000_3004;
        m0_Wvalid = 1; m0_Wdata = 32'h0000_0055; m0_Wstrb = 4'hF; #1;
        chk("rw_c0_busy", busy, 1'b0);
        cyc(); s_ARready = 1; #1;
        chk("rw_c1_grant", grant, 2'b01);
        chk("rw_c1_s_ARvalid", s_ARvalid, 1'b1);
        chk("rw_c1_s_ARdata", s_ARdata, 32'h0000_3000);
        chk("rw_c1_s_AWvalid", s_AWvalid, 1'b0);
        chk("rw_c1_s_Wvalid", s_Wvalid, 1'b0);
        cyc(); m0_ARvalid = 0; s_ARready = 0; s_Rvalid = 1; s_Rdata = 32'h0BAD_F00D; m0_RReady = 1; #1;
        chk("rw_c2_m0_Rdata", m0_Rdata, 32'h0BAD_F00D);
        cyc(); s_Rvalid = 0; s_Rdata = '0; m0_RReady = 0; #1;
        chk("rw_c3_busy", busy, 1'b0);
        cyc(); s_AWready = 1; s_Wready = 1; #1;
        chk("rw_c4_grant", grant, 2'b01);
        chk("rw_c4_s_AWvalid", s_AWvalid, 1'b1);
        chk("rw_c4_s_AWdata", s_AWdata, 32'h0000_3004);
        chk("rw_c4_s_Wvalid", s_Wvalid, 1'b1);
        chk("rw_c4_s_Wdata", s_Wdata, 32'h0000_0055);
        chk("rw_c4_s_ARvalid", s_ARvalid, 1'b0);
        chk("rw_c4_m0_AWready", m0_AWready, 1'b1);
        chk("rw_c4_m0_Wready", m0_Wready, 1'b1);
        cyc(); m0_AWvalid = 0; m0_Wvalid = 0; s_AWready = 0; s_Wready = 0; s_Bvalid = 1; m0_Bready = 1; #1;
        chk("rw_c5_m0_Bvalid", m0_Bvalid, 1'b1);
        chk("rw_c5_s_Bready", s_Bready, 1'b1);
        chk("rw_c5_m1_out", m1_out, '0);
        cyc(); clear_inputs(); #1;
        chk("rw_c6_busy", busy, 1'b0);

        // Response back-pressure: Rvalid with RReady low for 3 cycles
        cyc(); m0_ARvalid = 1; m0_ARdata = 32'h0000_4000; #1;
        cyc(); s_ARready = 1; #1;
        chk("bp_c1_grant", grant, 2'b01);
        for (int i = 0; i < 3; i++) begin
            cyc(); m0_ARvalid = 0; s_ARready = 0; s_Rvalid = 1; s_Rdata = 32'h0000_0077; m0_RReady = 0; #1;
            chk("bp_hold_s_RReady", s_RReady, 1'b0);
            chk("bp_hold_m0_Rvalid", m0_Rvalid, 1'b1);
            chk("bp_hold_busy", busy, 1'b1);
        end
        cyc(); m0_RReady = 1; #1;
        chk("bp_done_s_RReady", s_RReady, 1'b1);
        chk("bp_done_m0_Rdata", m0_Rdata, 32'h0000_0077);
        cyc(); clear_inputs(); #1;
        chk("bp_after_busy", busy, 1'b0);

        // Reset in RD_RESP with Rvalid low, then a tie must go to m0
        cyc(); m0_ARvalid = 1; m0_ARdata = 32'h0000_5000; #1;
        cyc(); s_ARready = 1; #1;
        chk("rst_c1_grant", grant, 2'b01);
        cyc(); m0_ARvalid = 0; s_ARready = 0; s_Rvalid = 0; m0_RReady = 1; reset = 1; #1;
        chk("rst_c2_busy", busy, 1'b1);
        chk("rst_c2_s_RReady", s_RReady, 1'b1);
        cyc(); reset = 0; s_Rvalid = 1; s_Rdata = 32'h0000_FFFF; #1;
        chk("rst_c3_busy", busy, 1'b0);
        chk("rst_c3_all_out", all_out, '0);
        cyc(); clear_inputs(); m0_ARvalid = 1; m1_ARvalid = 1; #1;
        chk("rst_c4_grant", grant, 2'b00);
        cyc(); #1;
        chk("rst_c5_tie_grant", grant, 2'b01);

        cyc(); clear_inputs(); reset = 1;
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
